// File: rtl/ddr_rd_burst.sv
// ddr_rd_burst: fixed-length AXI4 INCR read burst master that streams the returned beats into the pixel cache FIFO.
// Define DDR_RD_ERR_CHECK_EN to enable the sticky R-channel protocol error flag (err is tied to 0 otherwise).
module ddr_rd_burst #(
    parameter int unsigned BURST_LEN    = 64,
    parameter int unsigned FRAME_BURSTS = 3072,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic         sclk,
    input  logic         rst_n,
    input  logic         rd_start,
    output logic [127:0] rd_128bit_data,
    output logic         cache_wr_en,
    output logic         rd_end,
    output logic         frame_start,
    output logic         err,
    output logic [31:0]  m_axi_araddr,
    output logic [7:0]   m_axi_arlen,
    output logic [2:0]   m_axi_arsize,
    output logic [1:0]   m_axi_arburst,
    output logic         m_axi_arvalid,
    input  logic         m_axi_arready,
    input  logic [127:0] m_axi_rdata,
    input  logic [1:0]   m_axi_rresp,
    input  logic         m_axi_rlast,
    input  logic         m_axi_rvalid,
    output logic         m_axi_rready
);
    localparam int unsigned      IDX_W       = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
    localparam logic [7:0]       LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FRAME_BURSTS - 1);
    localparam logic [31:0]      BURST_BYTES = 32'(BURST_LEN * 16);

    typedef enum logic [1:0] {IDLE, AR, RDAT, DONE} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] burst_idx_reg;
    logic [7:0]       beat_cnt_reg;
    logic [31:0]      araddr_reg;
    logic [127:0]     rd_data_reg;
    logic             wr_en_reg;
    logic             frame_start_reg;
    logic             arvalid_next;
    logic             rready_next;
    logic             rd_end_next;
    logic             beat;
    logic             last_beat;
    logic             ar_hs;

    // rready is only high in RDAT, so a beat is rvalid qualified by the state.
    assign beat      = m_axi_rvalid && (state_reg == RDAT);
    assign last_beat = beat && (beat_cnt_reg == LAST_BEAT);
    assign ar_hs     = (state_reg == AR) && m_axi_arready;

    always_comb begin
        state_next   = state_reg;
        arvalid_next = 1'b0;
        rready_next  = 1'b0;
        rd_end_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rd_start) state_next = AR;
            end
            AR: begin
                arvalid_next = 1'b1;
                if (m_axi_arready) state_next = RDAT;
            end
            RDAT: begin
                rready_next = 1'b1;
                if (last_beat) state_next = DONE;
            end
            DONE: begin
                rd_end_next = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            burst_idx_reg   <= '0;
            beat_cnt_reg    <= '0;
            araddr_reg      <= BASE_ADDR;
            rd_data_reg     <= '0;
            wr_en_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wr_en_reg       <= beat;
            frame_start_reg <= ar_hs && (burst_idx_reg == '0);
            if (beat) begin
                rd_data_reg  <= m_axi_rdata;
                beat_cnt_reg <= beat_cnt_reg + 8'd1;
            end
            // Address is latched on acceptance so it stays put for the whole AR phase.
            if ((state_reg == IDLE) && rd_start) begin
                araddr_reg   <= BASE_ADDR + 32'(burst_idx_reg) * BURST_BYTES;
                beat_cnt_reg <= '0;
            end
            if (state_reg == DONE) begin
                burst_idx_reg <= (burst_idx_reg == LAST_IDX) ? '0 : burst_idx_reg + IDX_W'(1);
            end
        end
    end

`ifdef DDR_RD_ERR_CHECK_EN
    logic err_reg;

    // Flags bad response codes and rlast disagreeing with our own beat count; data flow ignores it.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (beat && ((m_axi_rresp != 2'b00) ||
                              (m_axi_rlast != (beat_cnt_reg == LAST_BEAT)))) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    logic unused_resp;

    assign unused_resp = ^{m_axi_rresp, m_axi_rlast};
    assign err         = 1'b0;
`endif

    assign rd_128bit_data = rd_data_reg;
    assign cache_wr_en    = wr_en_reg;
    assign rd_end         = rd_end_next;
    assign frame_start    = frame_start_reg;
    assign m_axi_araddr   = araddr_reg;
    assign m_axi_arlen    = LAST_BEAT;
    assign m_axi_arsize   = 3'd4;
    assign m_axi_arburst  = 2'b01;
    assign m_axi_arvalid  = arvalid_next;
    assign m_axi_rready   = rready_next;

endmodule

// File: tb/tb_ddr_rd_burst.sv
// Scoreboard bench for ddr_rd_burst: directed bursts push expected AR/data/frame_start entries,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_ddr_rd_burst;
    localparam int BL = 64;
`ifdef DDR_RD_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         sclk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rd_start = 1'b0;
    logic [127:0] rd_128bit_data;
    logic         cache_wr_en;
    logic         rd_end;
    logic         frame_start;
    logic         err;
    logic [31:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic [1:0]   m_axi_arburst;
    logic         m_axi_arvalid;
    logic         m_axi_arready = 1'b0;
    logic [127:0] m_axi_rdata = '0;
    logic [1:0]   m_axi_rresp = 2'b00;
    logic         m_axi_rlast = 1'b0;
    logic         m_axi_rvalid = 1'b0;
    logic         m_axi_rready;

    always #5 sclk = ~sclk;

    ddr_rd_burst #(
        .BURST_LEN   (BL),
        .FRAME_BURSTS(3),
        .BASE_ADDR   (32'h0000_0000)
    ) dut (
        .sclk          (sclk),
        .rst_n         (rst_n),
        .rd_start      (rd_start),
        .rd_128bit_data(rd_128bit_data),
        .cache_wr_en   (cache_wr_en),
        .rd_end        (rd_end),
        .frame_start   (frame_start),
        .err           (err),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    int           n_checks = 0;
    int           n_fail = 0;
    logic [127:0] exp_data[$];
    logic [31:0]  exp_addr[$];
    bit           exp_fs[$];
    int           mon_beats = 0;
    int           mon_ends = 0;
    int           exp_ends = 0;
    bit           prev_hs = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_data", rd_128bit_data, 0);
        check("rst_wr_en", cache_wr_en, 0);
        check("rst_rd_end", rd_end, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_err", err, 0);
        check("rst_arvalid", m_axi_arvalid, 0);
        check("rst_rready", m_axi_rready, 0);
        check("rst_araddr", m_axi_araddr, 32'h0);
    endtask

    // Monitor: AR handshakes, frame_start one cycle later, every written beat, burst completion.
    always @(negedge sclk) begin
        if (!rst_n) begin
            mon_beats = 0;
            prev_hs   = 1'b0;
        end else begin
            if (prev_hs) begin
                if (exp_fs.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL frame_start: handshake with no expectation queued");
                end else begin
                    check("frame_start", frame_start, exp_fs.pop_front());
                end
            end else if (frame_start) begin
                check("frame_start_spurious", frame_start, 0);
            end
            prev_hs = m_axi_arvalid && m_axi_arready;
            if (prev_hs) begin
                if (exp_addr.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL araddr: unexpected AR handshake at %0h", m_axi_araddr);
                end else begin
                    check("araddr", m_axi_araddr, exp_addr.pop_front());
                end
                check("arlen", m_axi_arlen, 8'd63);
                check("arsize", m_axi_arsize, 3'd4);
                check("arburst", m_axi_arburst, 2'b01);
            end
            if (cache_wr_en) begin
                if (exp_data.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL wr_data: unexpected write of %0h", rd_128bit_data);
                end else begin
                    check("wr_data", rd_128bit_data, exp_data.pop_front());
                end
                mon_beats++;
            end
            if (rd_end) begin
                check("rd_end_beats", mon_beats, BL);
                check("rd_end_with_last_wr", cache_wr_en, 1);
                mon_ends++;
                mon_beats = 0;
            end
        end
    end

    // Issues one burst. Negative indices disable the corresponding directed disturbance.
    task automatic run_burst(input logic [31:0] addr, input bit fs, input bit pulse, input int stall,
                             input bit gaps, input int poke_at, input int resp_at,
                             input int early_last_at, input int abort_at, input logic [31:0] tag);
        int t;
        exp_addr.push_back(addr);
        exp_fs.push_back(fs);
        if (pulse) begin
            @(posedge sclk); #1; rd_start = 1'b1;
            @(posedge sclk); #1; rd_start = 1'b0;
        end
        t = 0;
        while (!m_axi_arvalid && t < 20) begin
            @(posedge sclk); #1; t++;
        end
        check("arvalid_up", m_axi_arvalid, 1);
        for (int s = 0; s < stall; s++) begin
            check("araddr_stall", m_axi_araddr, addr);
            check("arvalid_stall", m_axi_arvalid, 1);
            check("rready_in_ar", m_axi_rready, 0);
            @(posedge sclk); #1;
        end
        m_axi_arready = 1'b1;
        @(posedge sclk); #1;
        m_axi_arready = 1'b0;
        check("rready_in_rdat", m_axi_rready, 1);
        for (int i = 0; i < BL; i++) begin
            if (i == abort_at) begin
                m_axi_rvalid = 1'b0;
                rst_n = 1'b0;
                #1;
                check_reset_outputs();
                exp_data.delete();
                repeat (2) @(posedge sclk);
                #1; rst_n = 1'b1;
                $display("burst addr=%08h tag=%0d aborted by reset at beat %0d", addr, tag, i);
                return;
            end
            if (gaps && i > 0) begin
                m_axi_rvalid = 1'b0;
                @(posedge sclk); #1;
                check("wr_en_gap", cache_wr_en, 0);
            end
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = {tag, 64'h0, 32'(i)};
            m_axi_rlast  = (i == BL - 1) || (i == early_last_at);
            m_axi_rresp  = (i == resp_at) ? 2'b10 : 2'b00;
            if (poke_at >= 0) rd_start = (i == poke_at);
            exp_data.push_back(m_axi_rdata);
            @(posedge sclk); #1;
            check("wr_en_follow", cache_wr_en, 1);
            if (i == resp_at || i == early_last_at) check("err_flag", err, ERR_EN);
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
        if (poke_at >= 0) rd_start = 1'b0;
        exp_ends++;
        check("rd_end_last", rd_end, 1);
        @(negedge sclk);
        $display("burst addr=%08h tag=%0d complete", addr, tag);
    endtask

    initial begin
        #1;
        check_reset_outputs();
        repeat (3) @(posedge sclk);
        #1; rst_n = 1'b1;

        run_burst(32'h000, 1'b1, 1'b1, 0, 1'b0, -1, -1, -1, -1, 0);
        run_burst(32'h400, 1'b0, 1'b1, 5, 1'b1, -1, -1, -1, -1, 1);
        run_burst(32'h800, 1'b0, 1'b1, 0, 1'b0, 20, -1, -1, -1, 2);
        for (int k = 0; k < 4; k++) begin
            @(negedge sclk);
            check("no_queued_request", m_axi_arvalid, 0);
        end
        run_burst(32'h000, 1'b1, 1'b1, 0, 1'b0, -1, -1, -1, -1, 3);
        check("err_clean", err, 0);

        rd_start = 1'b1;
        run_burst(32'h400, 1'b0, 1'b0, 0, 1'b0, -1, -1, -1, -1, 4);
        @(negedge sclk);
        check("held_idle_gap", m_axi_arvalid, 0);
        @(negedge sclk);
        check("held_retrigger", m_axi_arvalid, 1);
        rd_start = 1'b0;
        @(posedge sclk); #1;
        run_burst(32'h800, 1'b0, 1'b0, 0, 1'b0, -1, -1, -1, -1, 5);

        run_burst(32'h000, 1'b1, 1'b1, 0, 1'b0, -1, 10, -1, -1, 6);
        check("err_held", err, ERR_EN);

        run_burst(32'h400, 1'b0, 1'b1, 0, 1'b0, -1, -1, -1, 30, 7);
        check("err_after_reset", err, 0);
        run_burst(32'h000, 1'b1, 1'b1, 0, 1'b0, -1, -1, 5, -1, 8);
        check("err_early_rlast", err, ERR_EN);

        repeat (5) @(negedge sclk);
        check("data_queue_empty", exp_data.size(), 0);
        check("addr_queue_empty", exp_addr.size(), 0);
        check("fs_queue_empty", exp_fs.size(), 0);
        check("rd_end_count", mon_ends, exp_ends);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
